// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the fetch queue.
// master = queue side, slave = fetch/decode side.
interface fetch_queue_if #(
  parameter int AW = 2
);
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        branch_taken;
  logic        freeze;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic [AW:0] count;

  modport master (
    input  if_pc,
    input  if_instruction,
    input  branch_taken,
    input  id_ready,
    output freeze,
    output id_valid,
    output id_pc,
    output id_instruction,
    output count
  );

  modport slave (
    output if_pc,
    output if_instruction,
    output branch_taken,
    output id_ready,
    input  freeze,
    input  id_valid,
    input  id_pc,
    input  id_instruction,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO: captures {pc, instr} each unfrozen
// cycle, hands to decode by valid/ready, flushes on branch.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.master bus
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [63:0]   head;
  logic          full;
  logic          empty;
  logic          valid;
  logic          enq;
  logic          deq;

  assign full  = (cnt == FULL);
  assign empty = (cnt == '0);
  assign valid = ~empty & ~bus.branch_taken;
  assign enq   = ~full & ~bus.branch_taken;
  assign deq   = valid & bus.id_ready;
  assign head  = mem[rd_ptr];

  assign bus.freeze         = full;
  assign bus.id_valid       = valid;
  assign bus.count          = cnt;
  assign bus.id_pc          = empty ? 32'h0 : head[63:32];
  assign bus.id_instruction = empty ? 32'h0 : head[31:0];

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= {bus.if_pc, bus.if_instruction};
    end
  end

  // Flush wins over enqueue, dequeue and full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.branch_taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        (enq & ~deq): cnt <= cnt + 1'b1;
        (deq & ~enq): cnt <= cnt - 1'b1;
        default:      cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Random fetch/decode traffic against a queue-based model,
// with a monitor that checks every decode handshake.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.AW(AW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  bit mon_en = 1'b0;

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] target;
  bit prev_enq;
  bit prev_flush;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: compare state and pop on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("count", 64'(bus.count), 64'(exp_q.size()));
        chk("freeze", 64'(bus.freeze),
            64'(exp_q.size() == DEPTH));
        chk("id_valid", 64'(bus.id_valid),
            64'(exp_q.size() != 0 && !bus.branch_taken));
        if (exp_q.size() == 0)
          chk("id_empty_data",
              {bus.id_pc, bus.id_instruction}, 64'h0);
        if (bus.id_valid && bus.id_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deq got %0h want none",
                     bus.id_pc);
          end else begin
            chk("id_pair", {bus.id_pc, bus.id_instruction},
                exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Fetch model: pair consumed on every unfrozen,
  // non-branch cycle; a branch redirects to the target.
  task automatic drive(int p_branch, int p_ready);
    bit br;
    br = ($urandom_range(0, 99) < p_branch);
    bus.if_pc          = pc;
    bus.if_instruction = instr;
    bus.branch_taken   = br;
    bus.id_ready       = ($urandom_range(0, 99) < p_ready);
    prev_enq   = (exp_q.size() != DEPTH) && !br;
    prev_flush = br;
    if (br) target = 32'h40 + ($urandom & 32'hFFC);
  endtask

  task automatic step(int p_branch, int p_ready);
    @(posedge clk);
    #1;
    if (prev_flush) begin
      exp_q.delete();
      pc    = target;
      instr = $urandom;
    end else if (prev_enq) begin
      exp_q.push_back({pc, instr});
      pc    = pc + 32'd4;
      instr = $urandom;
    end
    drive(p_branch, p_ready);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_count", 64'(bus.count), 64'h0);
    chk("rst_valid", 64'(bus.id_valid), 64'h0);
    chk("rst_freeze", 64'(bus.freeze), 64'h0);
    chk("rst_id_pc", 64'(bus.id_pc), 64'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    pc     = 32'h0;
    instr  = $urandom;
    mon_en = 1'b1;
    drive(0, 100);
  endtask

  initial begin
    pc         = 32'h0;
    instr      = $urandom;
    target     = 32'h40;
    prev_enq   = 1'b0;
    prev_flush = 1'b0;
    bus.if_pc          = 32'h0;
    bus.if_instruction = 32'h0;
    bus.branch_taken   = 1'b0;
    bus.id_ready       = 1'b0;
    #3;
    chk("reset_count", 64'(bus.count), 64'h0);
    chk("reset_valid", 64'(bus.id_valid), 64'h0);
    chk("reset_freeze", 64'(bus.freeze), 64'h0);
    chk("reset_id_pc", 64'(bus.id_pc), 64'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    drive(0, 100);
    // Streaming with decode always ready.
    for (int i = 0; i < 12; i++) step(0, 100);
    // Fill to full, drain one, refill.
    pulse_reset();
    for (int i = 0; i < 8; i++) step(0, 0);
    step(0, 100);
    for (int i = 0; i < 4; i++) step(0, 0);
    // Flush while full and decode ready.
    step(100, 100);
    for (int i = 0; i < 4; i++) step(0, 30);
    // Back-to-back flushes.
    for (int i = 0; i < 3; i++) step(100, 50);
    for (int i = 0; i < 300; i++) step(8, 60);
    pulse_reset();
    for (int i = 0; i < 300; i++) step(5, 40);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
